// File: rtl/kernel3_gmem_c_m_axi_srl_fifo_pkg.sv
// ---------------------------------------------------------------------------
// kernel3_gmem_c_m_axi_srl_fifo_pkg
// Shared constants and helpers for the gmem_C m_axi shift-register FIFO.
//   GMEM_DATA_WIDTH : default payload width of the gmem_C data paths
//   RESET_ACTIVE    : level of 'reset' that clears the FIFO
//   fifoAddrWidth() : address width needed to index a given number of taps
// ---------------------------------------------------------------------------
package kernel3_gmem_c_m_axi_srl_fifo_pkg;

  localparam int GMEM_DATA_WIDTH = 32;

  localparam logic RESET_ACTIVE = 1'b1;

  // Smallest address width that can select any of 'taps' entries; a single
  // tap still needs one address bit so the port never collapses to zero width.
  function automatic int fifoAddrWidth(input int taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/kernel3_gmem_c_m_axi_fifo_store.sv
// ---------------------------------------------------------------------------
// kernel3_gmem_c_m_axi_fifo_store
// Shift-in storage with one addressed read tap. Every write pushes the whole
// array one slot deeper and puts the new word at slot 0, so the oldest word
// lives at the highest occupied slot. Contents are never reset.
//   clk_i     : clock
//   wrEn_i    : shift in wrData_i this cycle
//   wrData_i  : word to shift in
//   rdAddr_i  : tap to read (combinational)
//   rdData_o  : contents of slot rdAddr_i
// ---------------------------------------------------------------------------
module kernel3_gmem_c_m_axi_fifo_store
  import kernel3_gmem_c_m_axi_srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = GMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk_i,
  input  logic                  wrEn_i,
  input  logic [DATA_WIDTH-1:0] wrData_i,
  input  logic [ADDR_WIDTH-1:0] rdAddr_i,
  output logic [DATA_WIDTH-1:0] rdData_o
);

  localparam int Taps = DEPTH - 1;

  logic [DATA_WIDTH-1:0] mem [Taps];

  // Plain shift register with no reset so it maps onto SRL primitives; the
  // controller guarantees stale slots are never selected.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      for (int i = Taps - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= wrData_i;
    end
  end

  assign rdData_o = mem[rdAddr_i];

endmodule

// File: rtl/kernel3_gmem_c_m_axi_srl_fifo.sv
// ---------------------------------------------------------------------------
// kernel3_gmem_c_m_axi_srl_fifo
// Ready/valid FIFO for the gmem_C m_axi data paths. Words are shifted into a
// DEPTH-1 entry shift register and drained into a show-ahead output register,
// giving DEPTH entries of total capacity.
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset
//   clk_en         : global stall; nothing changes while low
//   s_valid/s_ready/s_data : upstream handshake and payload
//   m_valid/m_ready/m_data : downstream handshake and head-of-queue payload
//   num_data_valid : entries held in shift register plus output register
// ---------------------------------------------------------------------------
module kernel3_gmem_c_m_axi_srl_fifo
  import kernel3_gmem_c_m_axi_srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = GMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   num_data_valid
);

  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH+1)'(DEPTH - 1);

  logic                  push;
  logic                  rd;
  logic                  pop;
  logic [DATA_WIDTH-1:0] tapData;

  logic [ADDR_WIDTH:0]   count_q,    count_d;
  logic [ADDR_WIDTH-1:0] rdAddr_q,   rdAddr_d;
  logic                  srlEmpty_q, srlEmpty_d;
  logic                  sReady_q,   sReady_d;
  logic                  mValid_q,   mValid_d;
  logic [DATA_WIDTH-1:0] mData_q,    mData_d;
  logic [ADDR_WIDTH:0]   numData_q,  numData_d;

  // Qualified events. rd moves the oldest shift-register word into the output
  // register whenever that register is empty or being emptied this cycle.
  always_comb begin
    push = clk_en & s_valid & sReady_q;
    rd   = clk_en & ~srlEmpty_q & (~mValid_q | m_ready);
    pop  = clk_en & mValid_q & m_ready;
  end

  kernel3_gmem_c_m_axi_fifo_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk_i    (clk),
    .wrEn_i   (push),
    .wrData_i (s_data),
    .rdAddr_i (rdAddr_q),
    .rdData_o (tapData)
  );

  // Next-state for occupancy and flags. The read tap follows the count so it
  // always points at the oldest word; a read in the same cycle as a push still
  // sees the pre-shift contents, so the tap stays correct.
  always_comb begin
    count_d = count_q;
    if (push && !rd) begin
      count_d = count_q + 1'b1;
    end else if (rd && !push) begin
      count_d = count_q - 1'b1;
    end
    rdAddr_d   = (count_d != '0) ? ADDR_WIDTH'(count_d - 1'b1) : '0;
    srlEmpty_d = (count_d == '0);
    sReady_d   = (count_d != FullCount);
  end

  // Next-state for the show-ahead output register and the combined occupancy.
  always_comb begin
    mValid_d = mValid_q;
    mData_d  = mData_q;
    if (rd) begin
      mValid_d = 1'b1;
      mData_d  = tapData;
    end else if (pop) begin
      mValid_d = 1'b0;
    end
    numData_d = count_d + {{ADDR_WIDTH{1'b0}}, mValid_d};
  end

  // State registers; reset discards all occupancy but leaves storage alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset == RESET_ACTIVE) begin
      count_q    <= '0;
      rdAddr_q   <= '0;
      srlEmpty_q <= 1'b1;
      sReady_q   <= 1'b1;
      mValid_q   <= 1'b0;
      mData_q    <= '0;
      numData_q  <= '0;
    end else if (clk_en) begin
      count_q    <= count_d;
      rdAddr_q   <= rdAddr_d;
      srlEmpty_q <= srlEmpty_d;
      sReady_q   <= sReady_d;
      mValid_q   <= mValid_d;
      mData_q    <= mData_d;
      numData_q  <= numData_d;
    end
  end

  assign s_ready        = sReady_q;
  assign m_valid        = mValid_q;
  assign m_data         = mData_q;
  assign num_data_valid = numData_q;

endmodule

// File: tb/tb_kernel3_gmem_c_m_axi_srl_fifo.sv
// ---------------------------------------------------------------------------
// tb_kernel3_gmem_c_m_axi_srl_fifo
// Self-checking bench for the gmem_C shift-register FIFO. A queue-based
// reference holds the shift-register contents, the output register and the
// registered ready flag; each scenario task compares the DUT against it or
// against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_kernel3_gmem_c_m_axi_srl_fifo;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 63;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW:0]   num_data_valid;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: srlQ is the shift register (front = oldest),
  // mvM/mdM the output register, srM the registered ready flag.
  logic [DW-1:0] srlQ[$];
  logic          mvM;
  logic [DW-1:0] mdM;
  logic          srM;

  kernel3_gmem_c_m_axi_srl_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .num_data_valid (num_data_valid)
  );

  always #5 clk = ~clk;

  // Hard stop in case a scenario never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    srlQ.delete();
    mvM = 1'b0;
    mdM = '0;
    srM = 1'b1;
  endfunction

  function automatic logic [AW:0] modelCount();
    return (AW+1)'(srlQ.size()) + {{AW{1'b0}}, mvM};
  endfunction

  // One clock edge; the reference is advanced from the inputs seen at the edge.
  task automatic applyStimulus();
    logic          p, r, q;
    logic [DW-1:0] d;
    p = clk_en && s_valid && srM;
    r = clk_en && (srlQ.size() > 0) && (!mvM || m_ready);
    q = clk_en && mvM && m_ready;
    d = s_data;
    @(posedge clk);
    #1;
    if (r) begin
      mdM = srlQ.pop_front();
      mvM = 1'b1;
    end else if (q) begin
      mvM = 1'b0;
    end
    if (p) srlQ.push_back(d);
    srM = (srlQ.size() != DEPTH - 1);
  endtask

  task automatic doReset();
    reset   = 1'b1;
    clk_en  = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    doReset();
    vectors++;
    if ({s_ready, m_valid, num_data_valid, m_data} !== {1'b1, 1'b0, 7'd0, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got sr=%b mv=%b num=%0d data=%h, want sr=1 mv=0 num=0 data=0",
               s_ready, m_valid, num_data_valid, m_data);
    end
  endtask

  task automatic test_single_push();
    logic [AW:0] wantNum [3];
    logic        wantMv  [3];
    wantNum = '{7'd1, 7'd1, 7'd0};
    wantMv  = '{1'b0, 1'b1, 1'b0};
    doReset();
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      s_valid = 1'b0;
      vectors++;
      if (m_valid !== wantMv[c] || num_data_valid !== wantNum[c] ||
          (c == 1 && m_data !== 32'hDEADBEEF)) begin
        miscompares++;
        $display("[TB] FAIL single_push edge%0d: got mv=%b num=%0d data=%h, want mv=%b num=%0d data=deadbeef",
                 c, m_valid, num_data_valid, m_data, wantMv[c], wantNum[c]);
      end
    end
  endtask

  task automatic test_fill_drain();
    doReset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      s_data = DW'(i);
      applyStimulus();
    end
    s_valid = 1'b0;
    vectors++;
    if (s_ready !== 1'b0 || num_data_valid !== 7'd63) begin
      miscompares++;
      $display("[TB] FAIL fill_full: got sr=%b num=%0d, want sr=0 num=63", s_ready, num_data_valid);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 63; k++) begin
      vectors++;
      if (m_valid !== 1'b1 || m_data !== DW'(k)) begin
        miscompares++;
        $display("[TB] FAIL drain_order[%0d]: got mv=%b data=%0d, want mv=1 data=%0d", k, m_valid, m_data, k);
      end
      applyStimulus();
    end
    vectors++;
    if (m_valid !== 1'b0 || num_data_valid !== 7'd0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL drain_empty: got mv=%b num=%0d sr=%b, want mv=0 num=0 sr=1",
               m_valid, num_data_valid, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] base;
    doReset();
    base    = $urandom;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      s_data = base + DW'(c);
      applyStimulus();
      vectors++;
      if ((c >= 1 && (m_valid !== 1'b1 || m_data !== base + DW'(c - 1))) ||
          (c >= 1 && num_data_valid !== 7'd2) ||
          {s_ready, m_valid, num_data_valid, m_data} !== {srM, mvM, modelCount(), mdM}) begin
        miscompares++;
        $display("[TB] FAIL stream[%0d]: got mv=%b num=%0d data=%h, want mv=%b num=%0d data=%h",
                 c, m_valid, num_data_valid, m_data, mvM, modelCount(), mdM);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_full_boundary();
    doReset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 63; i++) begin
      s_data = $urandom;
      applyStimulus();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    applyStimulus();
    vectors++;
    if (s_ready !== 1'b1 || num_data_valid !== 7'd62) begin
      miscompares++;
      $display("[TB] FAIL full_single_pop: got sr=%b num=%0d, want sr=1 num=62", s_ready, num_data_valid);
    end
    s_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      s_data = $urandom;
      applyStimulus();
      vectors++;
      if ((num_data_valid !== 7'd62 && num_data_valid !== 7'd63) ||
          {s_ready, m_valid, num_data_valid, m_data} !== {srM, mvM, modelCount(), mdM}) begin
        miscompares++;
        $display("[TB] FAIL full_push_pop[%0d]: got sr=%b mv=%b num=%0d data=%h, want sr=%b mv=%b num=%0d data=%h",
                 c, s_ready, m_valid, num_data_valid, m_data, srM, mvM, modelCount(), mdM);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_clk_en();
    doReset();
    for (int c = 0; c < 600; c++) begin
      clk_en  = ($urandom_range(0, 9) < 7);
      s_valid = $urandom_range(0, 1);
      m_ready = ($urandom_range(0, 9) < 4);
      s_data  = $urandom;
      applyStimulus();
      vectors++;
      if ({s_ready, m_valid, num_data_valid, m_data} !== {srM, mvM, modelCount(), mdM}) begin
        miscompares++;
        $display("[TB] FAIL clk_en_traffic[%0d]: got sr=%b mv=%b num=%0d data=%h, want sr=%b mv=%b num=%0d data=%h",
                 c, s_ready, m_valid, num_data_valid, m_data, srM, mvM, modelCount(), mdM);
      end
    end
    clk_en  = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    doReset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 32'h1000 + DW'(i);
      applyStimulus();
    end
    s_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    vectors++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || num_data_valid !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got mv=%b sr=%b num=%0d, want mv=0 sr=1 num=0",
               m_valid, s_ready, num_data_valid);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 32'hA5;
    applyStimulus();
    s_valid = 1'b0;
    applyStimulus();
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 32'hA5 || num_data_valid !== 7'd1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_data: got mv=%b data=%h num=%0d, want mv=1 data=a5 num=1",
               m_valid, m_data, num_data_valid);
    end
    m_ready = 1'b1;
    applyStimulus();
    vectors++;
    if (m_valid !== 1'b0 || num_data_valid !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_stale: got mv=%b num=%0d data=%h, want mv=0 num=0",
               m_valid, num_data_valid, m_data);
    end
  endtask

  initial begin
    reset   = 1'b1;
    clk_en  = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    modelReset();
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_full_boundary();
    test_clk_en();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
